// File: rtl/off_chip_pkg.sv
`default_nettype none
// ============================================================================
// Module   : off_chip_pkg
// Purpose  : Definitions shared by both ends of the off-chip valid/ready link
//            (transmitter, receiver, equivalence wrapper).
// Contents : OFF_CHIP_DATA_W - link word width
//            link_beat_t     - one link beat {valid, data}
// Revision : 1.0 - initial release
// ============================================================================
package off_chip_pkg;

  localparam int OFF_CHIP_DATA_W = 64;

  typedef struct packed {
    logic                       valid;
    logic [OFF_CHIP_DATA_W-1:0] data;
  } link_beat_t;

endpackage
`default_nettype wire

// File: rtl/off_chip_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : off_chip_rx_fifo
// Purpose  : Synchronous elastic FIFO for the link receiver. A word written
//            in one cycle is readable the next; no write-to-read bypass.
// Ports    : clk, rst (async, active low)
//            push/wr_data - write request and word (ignored when full)
//            pop          - read request (ignored when empty)
//            rd_data      - head word, forced to 0 when empty
//            full, empty  - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module off_chip_rx_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] C_PTR_ONE  = 1;
  localparam logic [PTR_W:0]   C_OCC_ONE  = 1;
  localparam logic [PTR_W:0]   C_OCC_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    occ_q, occ_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push_ok, pop_ok;

  assign full    = (occ_q == C_OCC_FULL);
  assign empty   = (occ_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   occ_d = occ_q + C_OCC_ONE;
      2'b01:   occ_d = occ_q - C_OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is not reset; empty forces rd_data to 0 instead.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/off_chip_rx.sv
`default_nettype none
// ============================================================================
// Module   : off_chip_rx
// Purpose  : Receiving end of the off-chip valid/ready link. Buffers link
//            words in an elastic FIFO, counts accepted words and flags
//            sender protocol violations while stalled.
// Ports    : clk, rst (async, active low)
//            valid_in/data_in/ready - link side (from/to transmitter)
//            valid_out/data_out/ready_in - consumer side
//            word_cnt  - saturating count of accepted link words
//            proto_err - sticky protocol-violation flag
// Revision : 1.0 - initial release
// ============================================================================
module off_chip_rx
  import off_chip_pkg::*;
#(
  parameter int DATA_W = OFF_CHIP_DATA_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              proto_err
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE = 1;

  logic              push, pop, full, empty;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              stall_q, stall_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              proto_err_q, proto_err_d;

  // ready depends only on occupancy: a pop while full frees the slot for
  // the next cycle, never the current one.
  assign ready     = !full;
  assign valid_out = !empty;
  assign push      = valid_in && ready;
  assign pop       = valid_out && ready_in;

  off_chip_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (data_in),
    .pop     (pop),
    .rd_data (data_out),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (push && (word_cnt_q != C_CNT_MAX)) word_cnt_d = word_cnt_q + C_CNT_ONE;
  end

  // A beat offered but not accepted must be re-offered unchanged.
  always_comb begin
    stall_d     = valid_in && !ready;
    hold_d      = data_in;
    proto_err_d = proto_err_q;
    if (stall_q && (!valid_in || (data_in != hold_q))) proto_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt_q  <= '0;
      stall_q     <= 1'b0;
      hold_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      stall_q     <= stall_d;
      hold_q      <= hold_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign word_cnt  = word_cnt_q;
  assign proto_err = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_off_chip_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_off_chip_rx
// Purpose  : Self-checking bench for off_chip_rx. A queue-based model of the
//            link receiver predicts every output; a second instance with a
//            3-bit counter covers counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_off_chip_rx;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int CNT3_MAX = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              valid_in = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              ready_in = 1'b0;
  logic              ready, valid_out, proto_err;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  word_cnt;
  logic              ready3, valid_out3, proto_err3;
  logic [DATA_W-1:0] data_out3;
  logic [2:0]        word_cnt3;

  always #5 clk = ~clk;

  off_chip_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst_n), .valid_in(valid_in), .data_in(data_in),
    .ready(ready), .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in), .word_cnt(word_cnt), .proto_err(proto_err)
  );

  off_chip_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst_n), .valid_in(valid_in), .data_in(data_in),
    .ready(ready3), .data_out(data_out3), .valid_out(valid_out3),
    .ready_in(ready_in), .word_cnt(word_cnt3), .proto_err(proto_err3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents as a queue, plain integer counter.
  logic [DATA_W-1:0] mq[$];
  int                m_cnt;
  bit                m_err;
  bit                m_stall;
  logic [DATA_W-1:0] m_hold;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cnt   = 0;
    m_err   = 1'b0;
    m_stall = 1'b0;
    m_hold  = '0;
  endtask

  task automatic check_outputs();
    int c16, c3;
    c16 = (m_cnt > CNT_MAX) ? CNT_MAX : m_cnt;
    c3  = (m_cnt > CNT3_MAX) ? CNT3_MAX : m_cnt;
    check("ready", 64'(ready), 64'(mq.size() != DEPTH));
    check("valid_out", 64'(valid_out), 64'(mq.size() != 0));
    check("data_out", data_out, (mq.size() != 0) ? mq[0] : '0);
    check("word_cnt", 64'(word_cnt), 64'(c16));
    check("word_cnt_sat3", 64'(word_cnt3), 64'(c3));
    check("proto_err", 64'(proto_err), 64'(m_err));
  endtask

  // Called at a falling edge: drive, check, cross the rising edge, advance
  // the model, return at the next falling edge.
  task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit ri);
    bit rdy, vo;
    valid_in = v;
    data_in  = d;
    ready_in = ri;
    #1;
    check_outputs();
    rdy = (mq.size() != DEPTH);
    vo  = (mq.size() != 0);
    @(posedge clk);
    if (m_stall && (!v || d !== m_hold)) m_err = 1'b1;
    m_stall = v && !rdy;
    m_hold  = d;
    if (vo && ri) void'(mq.pop_front());
    if (v && rdy) begin
      mq.push_back(d);
      m_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit                v;
    logic [DATA_W-1:0] d;
    bit                ri;
    bit                e_rdy;
    bit                e_vo;
    logic [DATA_W-1:0] e_do;
    int                e_cnt;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] w1, w2, w3, w4;
    bit                pend_v, rdy;
    logic [DATA_W-1:0] pend_d;

    w1 = 64'h1111_0000_0000_0001;
    w2 = 64'h1111_0000_0000_0002;
    w3 = 64'h1111_0000_0000_0003;
    w4 = 64'h1111_0000_0000_0004;
    tbl[0] = '{1'b1, w1, 1'b0, 1'b1, 1'b0, '0, 0};
    tbl[1] = '{1'b1, w2, 1'b0, 1'b1, 1'b1, w1, 1};
    tbl[2] = '{1'b1, w3, 1'b0, 1'b1, 1'b1, w1, 2};
    tbl[3] = '{1'b1, w4, 1'b0, 1'b1, 1'b1, w1, 3};
    tbl[4] = '{1'b0, '0, 1'b0, 1'b0, 1'b1, w1, 4};
    tbl[5] = '{1'b0, '0, 1'b1, 1'b0, 1'b1, w1, 4};
    tbl[6] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, w2, 4};
    tbl[7] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, w3, 4};
    tbl[8] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, w4, 4};
    tbl[9] = '{1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 4};

    // Reset and idle
    @(negedge clk);
    apply_reset();
    step(1'b0, '0, 1'b0);

    // Fill with four words, then drain in order
    foreach (tbl[i]) begin
      valid_in = tbl[i].v;
      data_in  = tbl[i].d;
      ready_in = tbl[i].ri;
      #1;
      check("tbl_ready", 64'(ready), 64'(tbl[i].e_rdy));
      check("tbl_valid_out", 64'(valid_out), 64'(tbl[i].e_vo));
      check("tbl_data_out", data_out, tbl[i].e_do);
      check("tbl_word_cnt", 64'(word_cnt), 64'(tbl[i].e_cnt));
      step(tbl[i].v, tbl[i].d, tbl[i].ri);
    end

    // Full with pop and valid_in together: not accepted until next cycle
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 64'hC0 + 64'(i), 1'b0);
    step(1'b1, 64'h5A5A, 1'b1);
    check("full_pop_ready_next", 64'(ready), 64'd1);
    step(1'b1, 64'h5A5A, 1'b0);
    check("full_again_ready", 64'(ready), 64'd0);
    check("full_again_cnt", 64'(word_cnt), 64'd5);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

    // Back-to-back stream of 20 words, pointers wrap
    apply_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 64'hA000 + 64'(i), 1'b1);
    step(1'b0, '0, 1'b1);
    check("stream_cnt", 64'(word_cnt), 64'd20);
    check("stream_cnt_sat3", 64'(word_cnt3), 64'd7);
    check("stream_drained", 64'(valid_out), 64'd0);

    // Asynchronous reset with three words buffered
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 64'hB0 + 64'(i), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_word_cnt", 64'(word_cnt), 64'd0);
    check("rst_ready", 64'(ready), 64'd1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0);

    // Data changed while stalled
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 64'hD0 + 64'(i), 1'b0);
    step(1'b1, 64'hDEAD, 1'b0);
    step(1'b1, 64'hBEEF, 1'b0);
    check("err_data_change", 64'(proto_err), 64'd1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
    check("err_sticky", 64'(proto_err), 64'd1);

    // Valid withdrawn while stalled
    apply_reset();
    check("err_cleared", 64'(proto_err), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 64'hE0 + 64'(i), 1'b0);
    step(1'b1, 64'hDEAD, 1'b0);
    step(1'b0, '0, 1'b0);
    check("err_withdraw", 64'(proto_err), 64'd1);

    // Randomised protocol-compliant traffic
    apply_reset();
    pend_v = 1'b0;
    pend_d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend_v && ($urandom_range(0, 9) < 6)) begin
        pend_v = 1'b1;
        pend_d = {$urandom, $urandom};
      end
      rdy = (mq.size() != DEPTH);
      step(pend_v, pend_d, 1'($urandom_range(0, 1)));
      if (pend_v && rdy) pend_v = 1'b0;
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
    check("rand_no_err", 64'(proto_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
